// File: rtl/mvau_wmem_pkg.sv
// Shared types and helpers for the runtime-loadable MVAU weight memory.
package mvau_wmem_pkg;

  typedef enum logic {WMEM_LOAD, WMEM_RUN} wmem_state_t;

  localparam int unsigned DEF_PE      = 2;
  localparam int unsigned DEF_SIMD    = 2;
  localparam int unsigned DEF_TW      = 1;
  localparam int unsigned WORD_BW     = DEF_PE * DEF_SIMD * DEF_TW;

  // Address bits needed to index `value` entries; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/mvau_wmem_bank.sv
// Simple dual-port weight RAM: one write port, one synchronous read port, no array reset.
module mvau_wmem_bank #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_BW = 2
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_BW-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [ADDR_BW-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  (* ram_style = "auto" *) logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mvau_weight_stream_mem.sv
// Weight memory for one MVAU batch: filled over AXI-Stream, then streamed to the PE array
// by a wrapping read sequencer with a valid/last-qualified output.
module mvau_weight_stream_mem
  import mvau_wmem_pkg::*;
#(
  parameter int unsigned SIMD         = DEF_SIMD,
  parameter int unsigned PE           = DEF_PE,
  parameter int unsigned TW           = DEF_TW,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4,
  parameter int unsigned OREG         = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [PE*SIMD*TW-1:0]  s_wgt_tdata,
  input  logic                   s_wgt_tvalid,
  output logic                   s_wgt_tready,
  input  logic                   reload,
  output logic                   wmem_ready,
  input  logic                   rd_en,
  input  logic                   rd_restart,
  output logic [PE*SIMD*TW-1:0]  wmem_out,
  output logic                   wmem_valid,
  output logic                   wmem_last
);

  localparam int unsigned WordBw = PE * SIMD * TW;
  localparam int unsigned IdxBw  = clog2(WMEM_DEPTH);
  localparam logic [WMEM_ADDR_BW-1:0] LastAddr = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  wmem_state_t             state_q;
  logic [WMEM_ADDR_BW-1:0] wr_addr_q;
  logic [WMEM_ADDR_BW-1:0] rd_addr_q;
  logic                    wr_fire;
  logic                    rd_fire;
  logic                    rd_is_last;
  logic [WordBw-1:0]       rd_data;
  logic                    valid1_q;
  logic                    last1_q;

  assign s_wgt_tready = aresetn & (state_q == WMEM_LOAD);
  assign wmem_ready   = aresetn & (state_q == WMEM_RUN);

  // A reload in the same cycle discards both the incoming beat and any read request.
  assign wr_fire    = s_wgt_tvalid & s_wgt_tready & ~reload;
  assign rd_fire    = rd_en & (state_q == WMEM_RUN) & ~reload;
  assign rd_is_last = (rd_addr_q == LastAddr);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= WMEM_LOAD;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else if (reload) begin
      state_q   <= WMEM_LOAD;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      unique case (state_q)
        WMEM_LOAD: begin
          if (wr_fire) begin
            if (wr_addr_q == LastAddr) begin
              state_q   <= WMEM_RUN;
              wr_addr_q <= '0;
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        WMEM_RUN: begin
          // Restart wins over the advance of a coincident read.
          if (rd_restart) begin
            rd_addr_q <= '0;
          end else if (rd_fire) begin
            rd_addr_q <= rd_is_last ? '0 : rd_addr_q + 1'b1;
          end
        end
        default: state_q <= WMEM_LOAD;
      endcase
    end
  end

  mvau_wmem_bank #(
    .WIDTH   (WordBw),
    .DEPTH   (WMEM_DEPTH),
    .ADDR_BW (IdxBw)
  ) u_bank (
    .clk     (aclk),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr_q[IdxBw-1:0]),
    .wr_data (s_wgt_tdata),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr_q[IdxBw-1:0]),
    .rd_data (rd_data)
  );

  // First stage tracks the RAM read; reload does not flush reads already accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else begin
      valid1_q <= rd_fire;
      last1_q  <= rd_fire & rd_is_last;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic              valid2_q;
    logic              last2_q;
    logic [WordBw-1:0] out_q;

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        valid2_q <= 1'b0;
        last2_q  <= 1'b0;
        out_q    <= '0;
      end else begin
        valid2_q <= valid1_q;
        last2_q  <= last1_q;
        if (valid1_q) begin
          out_q <= rd_data;
        end
      end
    end

    assign wmem_valid = valid2_q;
    assign wmem_last  = last2_q;
    assign wmem_out   = out_q;
  end else begin : g_no_oreg
    // The RAM register is not reset, so mask it until a word has been read since reset.
    logic seen_q;

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        seen_q <= 1'b0;
      end else if (valid1_q) begin
        seen_q <= 1'b1;
      end
    end

    assign wmem_valid = valid1_q;
    assign wmem_last  = last1_q;
    assign wmem_out   = (seen_q | valid1_q) ? rd_data : '0;
  end

endmodule
